pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Sequences the 27 MHz → 150 MHz rPLL (IDIV 9, FBDIV 50, ODIV 4): holds the PLL in reset after power-up, waits for a lock that stays stable, then releases the rest of the drum-machine logic. It runs entirely on the free-running 27 MHz board clock, because the PLL output is not trustworthy while unlocked. It detects lock loss, retries a bounded number of times, and latches a fault that the operator can clear.

## Interface
Parameters:
- RESET_CYCLES, 32: cycles the PLL RESET is held per attempt (1..65535).
- LOCK_TIMEOUT, 27000: cycles allowed in WAIT_LOCK before a retry (1 ms at 27 MHz).
- STABLE_CYCLES, 2700: consecutive synchronized-high lock samples required before ready (100 µs).
- GLITCH_CYCLES, 4: consecutive low samples in RUN that count as a real loss of lock.
- MAX_RETRIES, 3: failed lock attempts allowed before FAULT (1..15).

Ports:
- clk  in  1  27 MHz board clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  rPLL LOCK; asynchronous to clk.
- retry  in  1  single-cycle pulse that leaves FAULT.
- pll_reset  out  1  drives rPLL RESET; active high.
- sys_ready  out  1  high only in RUN; downstream resets are released from this.
- fault  out  1  high in FAULT.
- state  out  3  current state code for debug.
- loss_count  out  8  saturating count of lock losses detected in RUN.

## Operation
- pll_lock passes through a 2-flop synchronizer (lk_s). All decisions use lk_s only.
- One 16-bit timer is cleared on every state entry.
- A 4-bit retry counter (rc) tracks failed lock attempts.
- States and codes:
  - RESET_PLL (0):
    - pll_reset=1.
    - After RESET_CYCLES cycles, go to WAIT_LOCK.
  - WAIT_LOCK (1):
    - If lk_s=1, go to STABLE.
    - If the timer reaches LOCK_TIMEOUT: rc++. If rc equals MAX_RETRIES, go to FAULT; otherwise go to RESET_PLL.
  - STABLE (2):
    - If lk_s=0, go to WAIT_LOCK. The timeout restarts; rc is unchanged.
    - After STABLE_CYCLES consecutive samples with lk_s=1, go to RUN and clear rc.
  - RUN (3):
    - sys_ready=1.
    - On the first lk_s=0 sample, sys_ready drops (see Timing).
    - If lk_s stays low for GLITCH_CYCLES consecutive samples: loss_count++ (saturates at 255), then go to RESET_PLL.
    - If lk_s returns high before GLITCH_CYCLES, go to STABLE. sys_ready stays low until stable again, and loss_count is not incremented.
  - FAULT (4):
    - pll_reset=1, fault=1.
    - Held indefinitely.
    - retry pulse: clear rc and go to RESET_PLL.
- retry is ignored in every state other than FAULT.
- Outputs are registered and decoded from the state register. There is no combinational path from pll_lock to any output.
- Reset values:
  - state=RESET_PLL, pll_reset=1.
  - sys_ready=0, fault=0.
  - loss_count=0, rc=0, timer=0, synchronizer flops 0.
- Reset mid-operation: all registers return to their reset values immediately (asynchronous assertion). pll_reset goes high and sys_ready goes low without waiting for a clock edge.

## Timing
- Synchronizer latency: a pll_lock edge is visible on lk_s 2 clk edges later.
- pll_reset:
  - After rst_n release, high for exactly RESET_CYCLES clk cycles.
  - Falls on the edge that enters WAIT_LOCK.
- Lock to ready: sys_ready rises exactly 2 + STABLE_CYCLES + 1 cycles after a clean pll_lock rise seen in WAIT_LOCK (sync, stable count, RUN register).
- Loss in RUN: sys_ready falls 1 cycle after the first lk_s=0 sample, i.e. 3 cycles after pll_lock falls.
- pll_reset rises GLITCH_CYCLES cycles after the first lk_s=0 sample.
- Timeout is exact: the transition happens on the cycle where timer = LOCK_TIMEOUT−1 with lk_s=0. If lk_s=1 on that same cycle, lock wins and the next state is STABLE.
- If the STABLE count completes and lk_s falls on the same cycle, the low sample wins and the next state is WAIT_LOCK.
- Saturation: loss_count holds at 255; rc never exceeds MAX_RETRIES.

## Test plan
Use RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, GLITCH_CYCLES=3, MAX_RETRIES=2 unless noted.
- Clean lock: release rst_n and raise pll_lock 10 cycles later, held high.
  - Required: pll_reset high for cycles 0–3.
  - Required: sys_ready rises at cycle 10+11=21 and stays high; fault=0; loss_count=0.
- Lock bounce in STABLE: pll_lock high for 5 cycles, low for 2, then high permanently.
  - Required: state returns to WAIT_LOCK, then STABLE.
  - Required: sys_ready rises only 11 cycles after the final rise; rc=0 afterwards.
- Glitch vs. loss in RUN: from RUN, drop pll_lock for 2 cycles.
  - Required: sys_ready low for a few cycles then re-asserts via STABLE; loss_count=0; pll_reset never asserts.
  - Then drop pll_lock permanently. Required: loss_count=1, pll_reset rises 5 cycles after the fall, state=RESET_PLL.
- Retry exhaustion and clear: hold pll_lock low.
  - Required: two RESET_PLL/WAIT_LOCK rounds of 4+20 cycles each, then state=FAULT, fault=1, pll_reset=1.
  - A retry pulse while not in FAULT has no effect.
  - A retry pulse in FAULT gives state=RESET_PLL and fault=0 on the next cycle.
- Reset mid-STABLE: assert rst_n low asynchronously between clk edges.
  - Required: pll_reset=1, sys_ready=0, loss_count=0 before the next edge.
  - Required: the sequence restarts from RESET_PLL after release.
- Saturation (GLITCH_CYCLES=1, STABLE_CYCLES=1): force 260 lock-loss/relock cycles.
  - Required: loss_count stops at 255 and never wraps.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// Power-up and lock supervisor for the 27 MHz -> 150 MHz rPLL. It runs on the board clock,
// holds the PLL in reset, qualifies lock, and releases downstream logic only after lock is stable.
module pll_lock_supervisor #(
  parameter int unsigned RESET_CYCLES  = 32,
  parameter int unsigned LOCK_TIMEOUT  = 27000,
  parameter int unsigned STABLE_CYCLES = 2700,
  parameter int unsigned GLITCH_CYCLES = 4,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       retry,
  output logic       pll_reset,
  output logic       sys_ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] loss_count
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam logic [15:0] RESET_LAST   = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] GLITCH_LAST  = 16'(GLITCH_CYCLES - 1);
  localparam logic [3:0]  RC_LIMIT     = 4'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        lk_s_q, lk_s_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  rc_q, rc_d;
  logic [7:0]  loss_q, loss_d;
  logic        pll_reset_q, pll_reset_d;
  logic        sys_ready_q, sys_ready_d;
  logic        fault_q, fault_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      sync1_q     <= 1'b0;
      lk_s_q      <= 1'b0;
      timer_q     <= '0;
      rc_q        <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      lk_s_q      <= lk_s_d;
      timer_q     <= timer_d;
      rc_q        <= rc_d;
      loss_q      <= loss_d;
      pll_reset_q <= pll_reset_d;
      sys_ready_q <= sys_ready_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    sync1_d = pll_lock;
    lk_s_d  = sync1_q;
    state_d = state_q;
    timer_d = timer_q + 16'd1;
    rc_d    = rc_q;
    loss_d  = loss_q;

    unique case (state_q)
      RESET_PLL: begin
        if (timer_q == RESET_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // A lock sample on the final timeout cycle still wins.
        if (lk_s_q) begin
          state_d = STABLE;
        end else if (timer_q == TIMEOUT_LAST) begin
          rc_d    = rc_q + 4'd1;
          state_d = (rc_q + 4'd1 == RC_LIMIT) ? FAULT : RESET_PLL;
        end
      end
      STABLE: begin
        if (!lk_s_q) begin
          state_d = WAIT_LOCK;
        end else if (timer_q == STABLE_LAST) begin
          state_d = RUN;
          rc_d    = '0;
        end
      end
      RUN: begin
        // Timer counts consecutive low samples; zero means lock has been steady.
        if (!lk_s_q) begin
          if (timer_q == GLITCH_LAST) begin
            state_d = RESET_PLL;
            loss_d  = sat_inc(loss_q);
          end
        end else begin
          timer_d = timer_q;
          if (timer_q != '0) state_d = STABLE;
        end
      end
      FAULT: begin
        timer_d = '0;
        if (retry) begin
          state_d = RESET_PLL;
          rc_d    = '0;
        end
      end
      default: state_d = RESET_PLL;
    endcase

    if (state_d != state_q) timer_d = '0;

    pll_reset_d = (state_d == RESET_PLL) || (state_d == FAULT);
    sys_ready_d = (state_d == RUN) && lk_s_q;
    fault_d     = (state_d == FAULT);
  end

  assign pll_reset  = pll_reset_q;
  assign sys_ready  = sys_ready_q;
  assign fault      = fault_q;
  assign state      = state_q;
  assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed vector tables, an async-reset sequence,
// randomized lock activity against a reference model, and loss-count saturation.
module tb_pll_lock_supervisor;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int GC = 3;
  localparam int MR = 2;

  localparam int M_RESET  = 0;
  localparam int M_WAIT   = 1;
  localparam int M_STABLE = 2;
  localparam int M_RUN    = 3;
  localparam int M_FAULT  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       retry = 1'b0;
  logic       pll_reset, sys_ready, fault;
  logic [2:0] state;
  logic [7:0] loss_count;

  logic       lock_b = 1'b0;
  logic       retry_b = 1'b0;
  logic       pll_reset_b, sys_ready_b, fault_b;
  logic [2:0] state_b;
  logic [7:0] loss_b;

  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
    .GLITCH_CYCLES(GC), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .retry(retry),
    .pll_reset(pll_reset), .sys_ready(sys_ready), .fault(fault),
    .state(state), .loss_count(loss_count)
  );

  pll_lock_supervisor #(
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(1),
    .GLITCH_CYCLES(1), .MAX_RETRIES(MR)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .pll_lock(lock_b), .retry(retry_b),
    .pll_reset(pll_reset_b), .sys_ready(sys_ready_b), .fault(fault_b),
    .state(state_b), .loss_count(loss_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a lock sample history plus dwell/streak/attempt counters
  bit lk_pipe[$];
  int m_mode, m_dwell, m_lows, m_fails, m_losses;
  bit m_ready;

  task automatic model_reset();
    lk_pipe  = '{1'b0, 1'b0};
    m_mode   = M_RESET;
    m_dwell  = 0;
    m_lows   = 0;
    m_fails  = 0;
    m_losses = 0;
    m_ready  = 1'b0;
  endtask

  task automatic model_step();
    bit lk;
    int next;
    lk = lk_pipe.pop_front();
    lk_pipe.push_back(pll_lock);
    next = m_mode;
    case (m_mode)
      M_RESET:  if (m_dwell + 1 >= RC) next = M_WAIT;
      M_WAIT: begin
        if (lk) next = M_STABLE;
        else if (m_dwell + 1 >= LT) begin
          m_fails++;
          next = (m_fails >= MR) ? M_FAULT : M_RESET;
        end
      end
      M_STABLE: begin
        if (!lk) next = M_WAIT;
        else if (m_dwell + 1 >= SC) begin
          next = M_RUN;
          m_fails = 0;
        end
      end
      M_RUN: begin
        if (!lk) begin
          if (m_lows + 1 >= GC) begin
            next = M_RESET;
            if (m_losses < 255) m_losses++;
          end
        end else if (m_lows > 0) next = M_STABLE;
      end
      default: if (retry) begin
        m_fails = 0;
        next = M_RESET;
      end
    endcase
    if (next != m_mode) begin
      m_dwell = 0;
      m_lows  = 0;
    end else begin
      m_dwell++;
      m_lows = (m_mode == M_RUN && !lk) ? m_lows + 1 : 0;
    end
    m_ready = (next == M_RUN) && lk;
    m_mode  = next;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    retry    = 1'b0;
    lock_b   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit    rst;
    bit    lock;
    bit    rtry;
    int    n;
    int    st;
    bit    prst;
    bit    rdy;
    bit    flt;
    int    loss;
    string name;
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];

  function automatic vec_t mk(bit r, bit l, bit t, int n, int st, bit p, bit y, bit f, int lc, string nm);
    vec_t v;
    v.rst = r; v.lock = l; v.rtry = t; v.n = n; v.st = st;
    v.prst = p; v.rdy = y; v.flt = f; v.loss = lc; v.name = nm;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    if (v.rst) do_reset();
    else begin
      pll_lock = v.lock;
      retry    = v.rtry;
      repeat (v.n) tick();
    end
    chk({v.name, ".state"}, state, v.st);
    chk({v.name, ".pll_reset"}, pll_reset, v.prst);
    chk({v.name, ".sys_ready"}, sys_ready, v.rdy);
    chk({v.name, ".fault"}, fault, v.flt);
    chk({v.name, ".loss_count"}, loss_count, v.loss);
  endtask

  initial begin
    int run_left;
    int k;

    // clean lock, glitch, real loss, retry exhaustion and fault clear
    tab_a.push_back(mk(1, 0, 0,  0, 0, 1, 0, 0, 0, "por"));
    tab_a.push_back(mk(0, 0, 0,  3, 0, 1, 0, 0, 0, "rst_hold"));
    tab_a.push_back(mk(0, 0, 0,  1, 1, 0, 0, 0, 0, "wait_entry"));
    tab_a.push_back(mk(0, 0, 0,  6, 1, 0, 0, 0, 0, "wait_idle"));
    tab_a.push_back(mk(0, 1, 0,  2, 1, 0, 0, 0, 0, "sync_lat"));
    tab_a.push_back(mk(0, 1, 0,  1, 2, 0, 0, 0, 0, "stable_entry"));
    tab_a.push_back(mk(0, 1, 0,  7, 2, 0, 0, 0, 0, "stable_last"));
    tab_a.push_back(mk(0, 1, 0,  1, 3, 0, 1, 0, 0, "ready_rise"));
    tab_a.push_back(mk(0, 1, 0, 10, 3, 0, 1, 0, 0, "run_hold"));
    tab_a.push_back(mk(0, 0, 0,  2, 3, 0, 1, 0, 0, "glitch_sync"));
    tab_a.push_back(mk(0, 1, 0,  1, 3, 0, 0, 0, 0, "glitch_drop"));
    tab_a.push_back(mk(0, 1, 0,  1, 3, 0, 0, 0, 0, "glitch_low2"));
    tab_a.push_back(mk(0, 1, 0,  1, 2, 0, 0, 0, 0, "glitch_stable"));
    tab_a.push_back(mk(0, 1, 0,  7, 2, 0, 0, 0, 0, "restable"));
    tab_a.push_back(mk(0, 1, 0,  1, 3, 0, 1, 0, 0, "reready"));
    tab_a.push_back(mk(0, 0, 0,  2, 3, 0, 1, 0, 0, "loss_sync"));
    tab_a.push_back(mk(0, 0, 0,  1, 3, 0, 0, 0, 0, "loss_drop"));
    tab_a.push_back(mk(0, 0, 0,  1, 3, 0, 0, 0, 0, "loss_low2"));
    tab_a.push_back(mk(0, 0, 0,  1, 0, 1, 0, 0, 1, "loss_reset"));
    tab_a.push_back(mk(0, 0, 0,  3, 0, 1, 0, 0, 1, "round1_rst"));
    tab_a.push_back(mk(0, 0, 0,  1, 1, 0, 0, 0, 1, "round1_wait"));
    tab_a.push_back(mk(0, 0, 0,  7, 1, 0, 0, 0, 1, "round1_mid"));
    tab_a.push_back(mk(0, 0, 1,  1, 1, 0, 0, 0, 1, "retry_ignored"));
    tab_a.push_back(mk(0, 0, 0, 11, 1, 0, 0, 0, 1, "round1_last"));
    tab_a.push_back(mk(0, 0, 0,  1, 0, 1, 0, 0, 1, "round2_rst"));
    tab_a.push_back(mk(0, 0, 0,  3, 0, 1, 0, 0, 1, "round2_rst_end"));
    tab_a.push_back(mk(0, 0, 0,  1, 1, 0, 0, 0, 1, "round2_wait"));
    tab_a.push_back(mk(0, 0, 0, 19, 1, 0, 0, 0, 1, "round2_last"));
    tab_a.push_back(mk(0, 0, 0,  1, 4, 1, 0, 1, 1, "fault_entry"));
    tab_a.push_back(mk(0, 0, 0, 20, 4, 1, 0, 1, 1, "fault_hold"));
    tab_a.push_back(mk(0, 0, 1,  1, 0, 1, 0, 0, 1, "fault_clear"));
    tab_a.push_back(mk(0, 0, 0,  4, 1, 0, 0, 0, 1, "post_clear"));
    tab_a.push_back(mk(0, 1, 0,  3, 2, 0, 0, 0, 1, "pre_reset_stable"));

    // lock bounce while in STABLE
    tab_b.push_back(mk(1, 0, 0,  0, 0, 1, 0, 0, 0, "por2"));
    tab_b.push_back(mk(0, 0, 0, 10, 1, 0, 0, 0, 0, "b_wait"));
    tab_b.push_back(mk(0, 1, 0,  3, 2, 0, 0, 0, 0, "b_stable"));
    tab_b.push_back(mk(0, 1, 0,  2, 2, 0, 0, 0, 0, "b_high5"));
    tab_b.push_back(mk(0, 0, 0,  2, 2, 0, 0, 0, 0, "b_low_sync"));
    tab_b.push_back(mk(0, 1, 0,  1, 1, 0, 0, 0, 0, "b_back_wait"));
    tab_b.push_back(mk(0, 1, 0,  2, 2, 0, 0, 0, 0, "b_restable"));
    tab_b.push_back(mk(0, 1, 0,  7, 2, 0, 0, 0, 0, "b_not_yet"));
    tab_b.push_back(mk(0, 1, 0,  1, 3, 0, 1, 0, 0, "b_ready"));

    foreach (tab_a[i]) run_vec(tab_a[i]);

    // asynchronous reset in the middle of STABLE, between clock edges
    tick();
    tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async.pll_reset", pll_reset, 1);
    chk("async.sys_ready", sys_ready, 0);
    chk("async.loss_count", loss_count, 0);
    chk("async.state", state, M_RESET);
    chk("async.fault", fault, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("restart.rst_state", state, M_RESET);
    chk("restart.pll_reset", pll_reset, 1);
    tick();
    chk("restart.wait", state, M_WAIT);
    tick();
    chk("restart.stable", state, M_STABLE);
    repeat (8) tick();
    chk("restart.run", state, M_RUN);
    chk("restart.ready", sys_ready, 1);

    foreach (tab_b[i]) run_vec(tab_b[i]);

    // randomized lock activity against the reference model
    do_reset();
    run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        pll_lock = ~pll_lock;
        run_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 60));
      end
      run_left--;
      retry = ($urandom_range(0, 19) == 0);
      tick();
      chk("rnd.state", state, m_mode);
      chk("rnd.pll_reset", pll_reset, (m_mode == M_RESET) || (m_mode == M_FAULT));
      chk("rnd.sys_ready", sys_ready, m_ready);
      chk("rnd.fault", fault, m_mode == M_FAULT);
      chk("rnd.loss_count", loss_count, m_losses);
    end
    retry = 1'b0;

    // loss counter saturation with one-sample glitch and stable windows
    do_reset();
    lock_b = 1'b1;
    for (int i = 0; i < 260; i++) begin
      k = 0;
      while (state_b != 3'd3 && k < 200) begin
        tick();
        k++;
      end
      chk("sat.reach_run", state_b, M_RUN);
      lock_b = 1'b0;
      k = 0;
      while (state_b != 3'd0 && k < 50) begin
        tick();
        k++;
      end
      chk("sat.loss_count", loss_b, (i + 1 > 255) ? 255 : i + 1);
      lock_b = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
